// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 execute stage: op encoding, MUL step count, FSM states.
package swt16_pkg;

  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_WORD_WIDTH = 16;
  localparam int IALU_WORD_WIDTH = 16;
  localparam int PC_WIDTH        = 12;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int REG_IDX_WIDTH   = 4;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_AND  = 4'h2;
  localparam logic [3:0] ALU_OP_OR   = 4'h3;
  localparam logic [3:0] ALU_OP_XOR  = 4'h4;
  localparam logic [3:0] ALU_OP_SHL  = 4'h5;
  localparam logic [3:0] ALU_OP_SHR  = 4'h6;
  localparam logic [3:0] ALU_OP_SRA  = 4'h7;
  localparam logic [3:0] ALU_OP_MOV  = 4'h8;
  localparam logic [3:0] ALU_OP_MUL  = 4'h9;
  localparam logic [3:0] ALU_OP_LDW  = 4'hA;
  localparam logic [3:0] ALU_OP_LDB  = 4'hB;
  localparam logic [3:0] ALU_OP_LDBU = 4'hC;
  localparam logic [3:0] ALU_OP_STW  = 4'hD;
  localparam logic [3:0] ALU_OP_STB  = 4'hE;

  localparam int         MUL_STEPS = 16;
  localparam logic [3:0] MUL_LAST  = 4'(MUL_STEPS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, 16 steps, low 16 bits kept.
// o_product shows the accumulator value after the current step so the caller can register it on the done edge.
module mul_iter
  import swt16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_product,
  output logic         o_done
);

  logic [W-1:0] r_mcand;
  logic [W-1:0] r_mplier;
  logic [W-1:0] r_acc;
  logic [3:0]   r_cnt;
  logic [W-1:0] w_acc_nxt;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_product = w_acc_nxt;
  assign o_done    = i_step && (r_cnt == MUL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/exec.sv
// swt16 execute stage: single-cycle ALU and DMEM address/data generation, 16-step iterative MUL.
// All outputs registered; out_busy holds upstream while a MUL is in flight.
module exec
  import swt16_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 in_alu_op,
  input  logic [IALU_WORD_WIDTH-1:0] in_opa,
  input  logic [IALU_WORD_WIDTH-1:0] in_opb,
  input  logic [IALU_WORD_WIDTH-1:0] in_imm,
  input  logic                       in_use_imm,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [2:0]                 in_cycle_in_instr,
  input  logic                       in_instr_is_bubble,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_act_write_res_to_reg,
  output logic                       out_busy,
  output logic                       out_act_load_dmem_word,
  output logic                       out_act_load_dmem_byte_signed,
  output logic                       out_act_load_dmem_byte_unsigned,
  output logic                       out_act_store_dmem_word,
  output logic                       out_act_store_dmem_byte,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic                       out_res_valid_MEM,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic                       out_act_write_res_to_reg,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [2:0]                 out_cycle_in_instr,
  output logic                       out_instr_is_bubble
);

  ex_state_e r_state, w_state_nxt;
  logic      w_mul_start, w_mul_step, w_mul_done;
  logic [IALU_WORD_WIDTH-1:0] w_mul_product;

  // Destination context of the in-flight MUL, replayed on the result edge.
  logic [REG_IDX_WIDTH-1:0]   r_mul_idx;
  logic                       r_mul_wr;
  logic [PMEM_WORD_WIDTH-1:0] r_mul_instr;
  logic [PC_WIDTH-1:0]        r_mul_pc;
  logic [2:0]                 r_mul_cyc;

  logic [IALU_WORD_WIDTH-1:0] w_bside, w_alu;
  logic [3:0]                 w_sh;
  logic [DMEM_ADDR_WIDTH-1:0] w_addr;
  logic                       w_is_load, w_issue;

  logic                       w_ld_w, w_ld_bs, w_ld_bu, w_st_w, w_st_b;
  logic [DMEM_ADDR_WIDTH-1:0] w_addr_o;
  logic [DMEM_WORD_WIDTH-1:0] w_wr_word;
  logic [IALU_WORD_WIDTH-1:0] w_res;
  logic                       w_valid, w_wr, w_bubble;
  logic [REG_IDX_WIDTH-1:0]   w_idx;
  logic [PMEM_WORD_WIDTH-1:0] w_instr;
  logic [PC_WIDTH-1:0]        w_pc;
  logic [2:0]                 w_cyc;

  logic                       r_busy;
  logic                       r_ld_w, r_ld_bs, r_ld_bu, r_st_w, r_st_b;
  logic [DMEM_ADDR_WIDTH-1:0] r_addr;
  logic [DMEM_WORD_WIDTH-1:0] r_wr_word;
  logic [IALU_WORD_WIDTH-1:0] r_res;
  logic                       r_valid, r_wr, r_bubble;
  logic [REG_IDX_WIDTH-1:0]   r_idx;
  logic [PMEM_WORD_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]        r_pc;
  logic [2:0]                 r_cyc;

  mul_iter #(.W(IALU_WORD_WIDTH)) u_mul (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_start   (w_mul_start),
    .i_step    (w_mul_step),
    .i_a       (in_opa),
    .i_b       (in_opb),
    .o_product (w_mul_product),
    .o_done    (w_mul_done)
  );

  assign w_bside   = in_use_imm ? in_imm : in_opb;
  assign w_sh      = w_bside[3:0];
  assign w_addr    = DMEM_ADDR_WIDTH'(in_opa + w_bside);
  assign w_is_load = (in_alu_op == ALU_OP_LDW) || (in_alu_op == ALU_OP_LDB) ||
                     (in_alu_op == ALU_OP_LDBU);
  assign w_issue   = (r_state == ST_IDLE) && !in_instr_is_bubble && (in_alu_op != ALU_OP_MUL);

  always_comb begin
    w_alu = '0;
    case (in_alu_op)
      ALU_OP_ADD: w_alu = in_opa + w_bside;
      ALU_OP_SUB: w_alu = in_opa - w_bside;
      ALU_OP_AND: w_alu = in_opa & w_bside;
      ALU_OP_OR:  w_alu = in_opa | w_bside;
      ALU_OP_XOR: w_alu = in_opa ^ w_bside;
      ALU_OP_SHL: w_alu = in_opa << w_sh;
      ALU_OP_SHR: w_alu = in_opa >> w_sh;
      ALU_OP_SRA: w_alu = $signed(in_opa) >>> w_sh;
      ALU_OP_MOV: w_alu = w_bside;
      default:    w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_mul_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!in_instr_is_bubble && (in_alu_op == ALU_OP_MUL)) begin
          w_state_nxt = ST_MUL;
          w_mul_start = 1'b1;
        end
      end
      ST_MUL: begin
        w_mul_step = 1'b1;
        if (w_mul_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Anything that is neither an issued single-cycle op nor a MUL result goes downstream as a bubble.
  always_comb begin
    w_ld_w    = 1'b0;
    w_ld_bs   = 1'b0;
    w_ld_bu   = 1'b0;
    w_st_w    = 1'b0;
    w_st_b    = 1'b0;
    w_addr_o  = '0;
    w_wr_word = '0;
    w_res     = '0;
    w_valid   = 1'b0;
    w_wr      = 1'b0;
    w_bubble  = 1'b1;
    w_idx     = '0;
    w_instr   = '0;
    w_pc      = '0;
    w_cyc     = '0;
    if (r_state == ST_MUL) begin
      if (w_mul_done) begin
        w_res    = w_mul_product;
        w_valid  = r_mul_wr;
        w_wr     = r_mul_wr;
        w_bubble = 1'b0;
        w_idx    = r_mul_idx;
        w_instr  = r_mul_instr;
        w_pc     = r_mul_pc;
        w_cyc    = r_mul_cyc;
      end
    end else if (w_issue) begin
      w_ld_w   = (in_alu_op == ALU_OP_LDW);
      w_ld_bs  = (in_alu_op == ALU_OP_LDB);
      w_ld_bu  = (in_alu_op == ALU_OP_LDBU);
      w_st_w   = (in_alu_op == ALU_OP_STW);
      w_st_b   = (in_alu_op == ALU_OP_STB);
      w_addr_o = w_addr;
      if (in_alu_op == ALU_OP_STW) w_wr_word = in_opb[DMEM_WORD_WIDTH-1:0];
      if (in_alu_op == ALU_OP_STB) w_wr_word = {2{in_opb[7:0]}};
      w_res    = w_alu;
      w_valid  = in_act_write_res_to_reg && !w_is_load;
      w_wr     = in_act_write_res_to_reg;
      w_bubble = 1'b0;
      w_idx    = in_res_reg_idx;
      w_instr  = in_instr;
      w_pc     = in_pc;
      w_cyc    = in_cycle_in_instr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_mul_idx   <= '0;
      r_mul_wr    <= 1'b0;
      r_mul_instr <= '0;
      r_mul_pc    <= '0;
      r_mul_cyc   <= '0;
      r_ld_w      <= 1'b0;
      r_ld_bs     <= 1'b0;
      r_ld_bu     <= 1'b0;
      r_st_w      <= 1'b0;
      r_st_b      <= 1'b0;
      r_addr      <= '0;
      r_wr_word   <= '0;
      r_res       <= '0;
      r_valid     <= 1'b0;
      r_wr        <= 1'b0;
      r_bubble    <= 1'b0;
      r_idx       <= '0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_cyc       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_MUL);
      if (w_mul_start) begin
        r_mul_idx   <= in_res_reg_idx;
        r_mul_wr    <= in_act_write_res_to_reg;
        r_mul_instr <= in_instr;
        r_mul_pc    <= in_pc;
        r_mul_cyc   <= in_cycle_in_instr;
      end
      r_ld_w    <= w_ld_w;
      r_ld_bs   <= w_ld_bs;
      r_ld_bu   <= w_ld_bu;
      r_st_w    <= w_st_w;
      r_st_b    <= w_st_b;
      r_addr    <= w_addr_o;
      r_wr_word <= w_wr_word;
      r_res     <= w_res;
      r_valid   <= w_valid;
      r_wr      <= w_wr;
      r_bubble  <= w_bubble;
      r_idx     <= w_idx;
      r_instr   <= w_instr;
      r_pc      <= w_pc;
      r_cyc     <= w_cyc;
    end
  end

  assign out_busy                        = r_busy;
  assign out_act_load_dmem_word          = r_ld_w;
  assign out_act_load_dmem_byte_signed   = r_ld_bs;
  assign out_act_load_dmem_byte_unsigned = r_ld_bu;
  assign out_act_store_dmem_word         = r_st_w;
  assign out_act_store_dmem_byte         = r_st_b;
  assign out_mem_rd_addr                 = r_addr;
  assign out_mem_wr_addr                 = r_addr;
  assign out_mem_wr_word                 = r_wr_word;
  assign out_res                         = r_res;
  assign out_res_valid_MEM               = r_valid;
  assign out_res_reg_idx                 = r_idx;
  assign out_act_write_res_to_reg        = r_wr;
  assign out_instr                       = r_instr;
  assign out_pc                          = r_pc;
  assign out_cycle_in_instr              = r_cyc;
  assign out_instr_is_bubble             = r_bubble;

endmodule

// File: tb/tb_exec.sv
// Directed bench for exec: ALU, memory ops, iterative MUL timing/results and reset behaviour.
module tb_exec;
  import swt16_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  in_alu_op;
  logic [15:0] in_opa, in_opb, in_imm;
  logic        in_use_imm;
  logic [15:0] in_instr;
  logic [11:0] in_pc;
  logic [2:0]  in_cycle_in_instr;
  logic        in_instr_is_bubble;
  logic [3:0]  in_res_reg_idx;
  logic        in_act_write_res_to_reg;

  logic        out_busy;
  logic        out_act_load_dmem_word, out_act_load_dmem_byte_signed, out_act_load_dmem_byte_unsigned;
  logic        out_act_store_dmem_word, out_act_store_dmem_byte;
  logic [11:0] out_mem_rd_addr, out_mem_wr_addr;
  logic [15:0] out_mem_wr_word, out_res;
  logic        out_res_valid_MEM;
  logic [3:0]  out_res_reg_idx;
  logic        out_act_write_res_to_reg;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic [2:0]  out_cycle_in_instr;
  logic        out_instr_is_bubble;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  exec dut (
    .clock(clock), .reset(reset),
    .in_alu_op(in_alu_op), .in_opa(in_opa), .in_opb(in_opb), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_instr(in_instr), .in_pc(in_pc),
    .in_cycle_in_instr(in_cycle_in_instr), .in_instr_is_bubble(in_instr_is_bubble),
    .in_res_reg_idx(in_res_reg_idx), .in_act_write_res_to_reg(in_act_write_res_to_reg),
    .out_busy(out_busy),
    .out_act_load_dmem_word(out_act_load_dmem_word),
    .out_act_load_dmem_byte_signed(out_act_load_dmem_byte_signed),
    .out_act_load_dmem_byte_unsigned(out_act_load_dmem_byte_unsigned),
    .out_act_store_dmem_word(out_act_store_dmem_word),
    .out_act_store_dmem_byte(out_act_store_dmem_byte),
    .out_mem_rd_addr(out_mem_rd_addr), .out_mem_wr_addr(out_mem_wr_addr),
    .out_mem_wr_word(out_mem_wr_word), .out_res(out_res),
    .out_res_valid_MEM(out_res_valid_MEM), .out_res_reg_idx(out_res_reg_idx),
    .out_act_write_res_to_reg(out_act_write_res_to_reg), .out_instr(out_instr),
    .out_pc(out_pc), .out_cycle_in_instr(out_cycle_in_instr),
    .out_instr_is_bubble(out_instr_is_bubble)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic use_imm, input logic wr,
                       input logic [3:0] idx);
    in_alu_op               = op;
    in_opa                  = a;
    in_opb                  = b;
    in_imm                  = imm;
    in_use_imm              = use_imm;
    in_act_write_res_to_reg = wr;
    in_res_reg_idx          = idx;
    in_instr_is_bubble      = 1'b0;
    in_instr                = {op, 12'h0A5};
    in_pc                   = in_pc + 12'd1;
    in_cycle_in_instr       = 3'd2;
  endtask

  task automatic drive_bubble();
    in_instr_is_bubble      = 1'b1;
    in_act_write_res_to_reg = 1'b0;
    in_alu_op               = ALU_OP_ADD;
  endtask

  // Called at the first negedge after MUL acceptance; counts busy cycles then checks the result.
  task automatic mul_finish(input string tag, input logic [15:0] exp, input logic [3:0] idx);
    int n = 0;
    while (out_busy === 1'b1 && n < 40) begin
      if (n == 0 || n == 15) check({tag, "_bubble_during"}, 32'(out_instr_is_bubble), 32'd1);
      n++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd16);
    check({tag, "_res"}, 32'(out_res), 32'(exp));
    check({tag, "_valid"}, 32'(out_res_valid_MEM), 32'd1);
    check({tag, "_idx"}, 32'(out_res_reg_idx), 32'(idx));
  endtask

  initial begin
    reset = 1'b0;
    in_pc = '0;
    drive(ALU_OP_ADD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0);
    drive_bubble();
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_res", 32'(out_res), 32'd0);
    check("rst_bubble", 32'(out_instr_is_bubble), 32'd0);
    check("rst_wr", 32'(out_act_write_res_to_reg), 32'd0);
    reset = 1'b1;

    drive(ALU_OP_ADD, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b1, 4'h3);
    @(negedge clock);
    check("add_res", 32'(out_res), 32'h8000);
    check("add_valid", 32'(out_res_valid_MEM), 32'd1);
    check("add_idx", 32'(out_res_reg_idx), 32'h3);

    drive(ALU_OP_SUB, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b1, 4'h4);
    @(negedge clock);
    check("sub_res", 32'(out_res), 32'hFFFF);

    drive(ALU_OP_SRA, 16'h8000, 16'h0000, 16'h0004, 1'b1, 1'b1, 4'h5);
    @(negedge clock);
    check("sra_res", 32'(out_res), 32'hF800);
    check("sra_valid", 32'(out_res_valid_MEM), 32'd1);

    drive(ALU_OP_LDB, 16'h0FFF, 16'h0000, 16'h0002, 1'b1, 1'b1, 4'h6);
    @(negedge clock);
    check("ldb_addr", 32'(out_mem_rd_addr), 32'h001);
    check("ldb_flag", 32'(out_act_load_dmem_byte_signed), 32'd1);
    check("ldb_other", 32'({out_act_load_dmem_word, out_act_load_dmem_byte_unsigned,
                            out_act_store_dmem_word, out_act_store_dmem_byte}), 32'd0);
    check("ldb_valid", 32'(out_res_valid_MEM), 32'd0);
    check("ldb_res", 32'(out_res), 32'd0);

    drive(ALU_OP_STB, 16'h0100, 16'h12AB, 16'h0003, 1'b1, 1'b0, 4'h0);
    @(negedge clock);
    check("stb_word", 32'(out_mem_wr_word), 32'hABAB);
    check("stb_flag", 32'(out_act_store_dmem_byte), 32'd1);
    check("stb_addr", 32'(out_mem_wr_addr), 32'h103);

    drive_bubble();
    @(negedge clock);
    check("bub_flag", 32'(out_instr_is_bubble), 32'd1);
    check("bub_acts", 32'({out_act_store_dmem_byte, out_act_load_dmem_byte_signed,
                           out_act_write_res_to_reg, out_res_valid_MEM}), 32'd0);

    // MUL with an ADD held upstream behind it
    drive(ALU_OP_MUL, 16'h0123, 16'h0010, 16'h0, 1'b0, 1'b1, 4'h7);
    @(negedge clock);
    check("mul1_busy_rise", 32'(out_busy), 32'd1);
    drive(ALU_OP_ADD, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b1, 4'h8);
    mul_finish("mul1", 16'h1230, 4'h7);
    @(negedge clock);
    check("held_add_res", 32'(out_res), 32'h0005);
    check("held_add_idx", 32'(out_res_reg_idx), 32'h8);

    drive(ALU_OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b1, 4'h9);
    @(negedge clock);
    drive_bubble();
    mul_finish("mul_ffff", 16'h0001, 4'h9);

    drive(ALU_OP_MUL, 16'h1234, 16'h0000, 16'h0, 1'b0, 1'b1, 4'hA);
    @(negedge clock);
    drive_bubble();
    mul_finish("mul_zero", 16'h0000, 4'hA);

    // back-to-back: second MUL held during the first
    drive(ALU_OP_MUL, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b1, 4'hB);
    @(negedge clock);
    drive(ALU_OP_MUL, 16'h0100, 16'h0101, 16'h0, 1'b0, 1'b1, 4'hC);
    mul_finish("b2b_a", 16'h000F, 4'hB);
    @(negedge clock);
    drive_bubble();
    mul_finish("b2b_b", 16'h0100, 4'hC);

    // reset during MUL
    drive(ALU_OP_MUL, 16'h0005, 16'h0007, 16'h0, 1'b0, 1'b1, 4'hD);
    @(negedge clock);
    drive(ALU_OP_ADD, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b1, 4'hE);
    repeat (7) @(negedge clock);
    check("mid_mul_busy", 32'(out_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(out_busy), 32'd0);
    check("arst_res", 32'(out_res), 32'd0);
    check("arst_bubble", 32'(out_instr_is_bubble), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_res", 32'(out_res), 32'h0002);
    check("post_rst_valid", 32'(out_res_valid_MEM), 32'd1);
    check("post_rst_busy", 32'(out_busy), 32'd0);
    drive_bubble();
    repeat (18) begin
      @(negedge clock);
      if (out_res_valid_MEM === 1'b1 || out_busy !== 1'b0)
        check("post_rst_quiet", 32'({out_busy, out_res_valid_MEM}), 32'd0);
    end
    check("post_rst_final_res", 32'(out_res), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
